// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch stage
package fetch_pkg;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef logic [1:0] epoch_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   typedef struct packed {
      epoch_t      epoch;
      logic [31:0] pc;
   } fetch_tag_t;
endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// rtl/fetch_pc_ctrl_if.sv - instruction memory request/response bundle
interface fetch_pc_ctrl_if;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data
   );
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with clear and occupancy count
module fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic                       i_clear,
   input  logic [WIDTH-1:0]           i_wdata,
   output logic [WIDTH-1:0]           o_rdata,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_empty,
   output logic                       o_full
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_rptr;
   logic [AW-1:0]    r_wptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   // explicit wrap so non-power-of-2 depths work
   function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign w_pop   = i_pop && !o_empty;
   assign w_push  = i_push && (!o_full || w_pop);
   assign o_rdata = r_mem[r_rptr];
   assign o_count = r_count;
   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CW'(DEPTH));

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= i_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_rptr  <= '0;
         r_wptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= ptr_next(r_wptr);
         end
         if (w_pop) begin
            r_rptr <= ptr_next(r_rptr);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CW'(1);
         end
      end
   end
endmodule

// File: rtl/fetch_pc_ctrl.sv
// rtl/fetch_pc_ctrl.sv - fetch stage: PC, in-order imem requests, response buffer, IF/ID
// Stale responses are recognised by the epoch captured alongside each request's pc.
module fetch_pc_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FBUF_DEPTH = 2,
   parameter int          MAX_OUTST  = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   br_taken,
   input  logic [31:0]            br_targetE,
   input  logic                   stallF,
   fetch_pc_ctrl_if.master        imem,
   output logic [31:0]            instrD,
   output logic [31:0]            pcD,
   output logic [31:0]            pcplus4D,
   output logic                   validD,
   output logic                   flush_DE
);
   localparam int TCW = $clog2(MAX_OUTST + 1);
   localparam int BCW = $clog2(FBUF_DEPTH + 1);

   logic [31:0]    r_pc;
   epoch_t         r_epoch;
   logic [31:0]    r_instrD;
   logic [31:0]    r_pcD;
   logic           r_validD;

   logic [TCW-1:0] w_outst;
   logic [BCW-1:0] w_buf_count;
   logic           w_tag_empty;
   logic           w_tag_full;
   logic           w_buf_empty;
   logic           w_buf_full;
   fetch_tag_t     w_tag_in;
   fetch_tag_t     w_tag_out;
   fetch_entry_t   w_ent_in;
   fetch_entry_t   w_ent_out;
   logic           w_req_valid;
   logic           w_req_fire;
   logic           w_rsp_fire;
   logic           w_buf_push;
   logic           w_buf_pop;

   // in-flight plus buffered never exceeds the buffer, so a response always has a slot
   assign w_req_valid = !rst && !w_tag_full &&
                        ((32'(w_outst) + 32'(w_buf_count)) < 32'(FBUF_DEPTH));
   assign w_req_fire  = w_req_valid && imem.imem_req_ready;
   assign w_rsp_fire  = !rst && imem.imem_rsp_valid;
   assign w_buf_push  = w_rsp_fire && !br_taken && (w_tag_out.epoch == r_epoch);
   assign w_buf_pop   = !rst && !br_taken && !stallF && !w_buf_empty;

   assign w_tag_in = '{epoch: r_epoch, pc: r_pc};
   assign w_ent_in = '{pc: w_tag_out.pc, instr: imem.imem_rsp_data};

   assign imem.imem_req_valid = w_req_valid;
   assign imem.imem_req_addr  = r_pc;

   assign instrD   = r_instrD;
   assign pcD      = r_pcD;
   assign pcplus4D = r_pcD + 32'd4;
   assign validD   = r_validD;
   assign flush_DE = br_taken;

   fetch_fifo #(.WIDTH($bits(fetch_tag_t)), .DEPTH(MAX_OUTST)) u_tag_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_req_fire),
      .i_pop   (w_rsp_fire),
      .i_clear (1'b0),
      .i_wdata (w_tag_in),
      .o_rdata (w_tag_out),
      .o_count (w_outst),
      .o_empty (w_tag_empty),
      .o_full  (w_tag_full)
   );

   fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FBUF_DEPTH)) u_rsp_buf (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_buf_push),
      .i_pop   (w_buf_pop),
      .i_clear (br_taken),
      .i_wdata (w_ent_in),
      .o_rdata (w_ent_out),
      .o_count (w_buf_count),
      .o_empty (w_buf_empty),
      .o_full  (w_buf_full)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc    <= RESET_PC;
         r_epoch <= '0;
      end else if (br_taken) begin
         r_pc    <= {br_targetE[31:1], 1'b0};
         r_epoch <= r_epoch + epoch_t'(1);
      end else if (w_req_fire) begin
         r_pc    <= r_pc + 32'd4;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_validD <= 1'b0;
         r_instrD <= NOP_INSTR;
         r_pcD    <= '0;
      end else if (br_taken) begin
         r_validD <= 1'b0;
         r_instrD <= NOP_INSTR;
      end else if (!stallF) begin
         if (!w_buf_empty) begin
            r_validD <= 1'b1;
            r_instrD <= w_ent_out.instr;
            r_pcD    <= w_ent_out.pc;
         end else begin
            r_validD <= 1'b0;
            r_instrD <= NOP_INSTR;
         end
      end
   end

   a_rsp_needs_outst: assert property (@(posedge clk) disable iff (rst)
      imem.imem_rsp_valid |-> !w_tag_empty);
   a_buf_no_overflow: assert property (@(posedge clk) disable iff (rst)
      w_buf_push |-> (!w_buf_full || w_buf_pop));
   a_req_aligned: assert property (@(posedge clk) disable iff (rst)
      imem.imem_req_valid |-> (imem.imem_req_addr[1:0] == 2'b00));
endmodule
